// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller.
// Optional bonus-ball feature is selected with the PONG_BONUS_BALL_EN macro.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } game_state_t;

  localparam int          TIMER_W      = 7;
  localparam logic [6:0]  TIMER_FRAMES = 7'd120;
  localparam logic [1:0]  MAX_BALLS    = 2'd3;
  localparam logic [9:0]  REFR_Y       = 10'd481;
  localparam logic [3:0]  BCD_MAX      = 4'd9;

  // Next value of a single BCD digit, wrapping 9 -> 0.
  function automatic logic [3:0] bcd_next(input logic [3:0] d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/pong_bcd_counter2.sv
// Two-digit BCD score counter with synchronous clear and increment.
// carry flags the ones digit wrapping 9 -> 0 on the current increment.
module pong_bcd_counter2
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       carry
);

  logic [3:0] digit_reg [2];
  logic [3:0] digit_next [2];
  logic [2:0] ripple;

  assign ripple[0] = inc;

  // Each digit advances when every lower digit wraps on this increment.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      assign ripple[gi+1] = ripple[gi] && (digit_reg[gi] == BCD_MAX);

      always_comb begin
        digit_next[gi] = digit_reg[gi];
        if (clr)
          digit_next[gi] = 4'd0;
        else if (ripple[gi])
          digit_next[gi] = bcd_next(digit_reg[gi]);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          digit_reg[gi] <= 4'd0;
        else
          digit_reg[gi] <= digit_next[gi];
      end
    end
  endgenerate

  assign d0    = digit_reg[0];
  assign d1    = digit_reg[1];
  assign carry = ripple[1];

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: state machine, ball count, score and restart timer.
// Define PONG_BONUS_BALL_EN to award a ball each time the ones digit wraps.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls
);

`ifdef PONG_BONUS_BALL_EN
  localparam logic BONUS_EN = 1'b1;
`else
  localparam logic BONUS_EN = 1'b0;
`endif

  game_state_t        state_reg, state_next;
  logic [1:0]         balls_reg, balls_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               hit_d_reg, miss_d_reg;
  logic               gra_still_reg;

  logic refr_tick, hit_rise, miss_rise, btn_press, timer_up;
  logic score_clr, score_inc, score_carry;

  assign refr_tick = (pix_y == REFR_Y) && (pix_x == 10'd0);
  assign hit_rise  = hit  & ~hit_d_reg;
  assign miss_rise = miss & ~miss_d_reg;
  assign btn_press = |btn;
  assign timer_up  = (timer_reg == '0);

  // Miss has priority, so a simultaneous hit never scores.
  assign score_inc = (state_reg == ST_PLAY) && hit_rise && !miss_rise;
  assign score_clr = (state_reg == ST_NEWGAME) ||
                     ((state_reg == ST_OVER) && timer_up);

  pong_bcd_counter2 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .d1    (score_d1),
    .d0    (score_d0),
    .carry (score_carry)
  );

  always_comb begin
    state_next = state_reg;
    balls_next = balls_reg;
    timer_next = (refr_tick && !timer_up) ? timer_reg - 7'd1 : timer_reg;
    case (state_reg)
      ST_NEWGAME: begin
        balls_next = MAX_BALLS;
        if (btn_press)
          state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (miss_rise) begin
          timer_next = TIMER_FRAMES;
          if (balls_reg == 2'd1) begin
            state_next = ST_OVER;
            balls_next = 2'd0;
          end else begin
            state_next = ST_NEWBALL;
            balls_next = balls_reg - 2'd1;
          end
        end else if (BONUS_EN && score_carry && (balls_reg != MAX_BALLS)) begin
          balls_next = balls_reg + 2'd1;
        end
      end
      ST_NEWBALL: begin
        if (timer_up && btn_press)
          state_next = ST_PLAY;
      end
      ST_OVER: begin
        if (timer_up) begin
          state_next = ST_NEWGAME;
          balls_next = MAX_BALLS;
        end
      end
      default: state_next = ST_NEWGAME;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_NEWGAME;
      balls_reg     <= MAX_BALLS;
      timer_reg     <= '0;
      hit_d_reg     <= 1'b0;
      miss_d_reg    <= 1'b0;
      gra_still_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      balls_reg     <= balls_next;
      timer_reg     <= timer_next;
      hit_d_reg     <= hit;
      miss_d_reg    <= miss;
      gra_still_reg <= (state_next != ST_PLAY);
    end
  end

  assign game_state = state_reg;
  assign gra_still  = gra_still_reg;
  assign balls      = balls_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (both PONG_BONUS_BALL_EN builds).
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn;
  logic [9:0] pix_x, pix_y;
  logic       hit, miss;
  logic       gra_still;
  logic [1:0] game_state;
  logic [3:0] score_d1, score_d0;
  logic [1:0] balls;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [1:0] exp_balls;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .game_state (game_state),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .balls      (balls)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      pix_y = 10'd481; pix_x = 10'd0;
      tick();
      pix_y = 10'd0;
      tick();
    end
  endtask

  task automatic hit_pulse();
    hit = 1'b1; tick();
    hit = 1'b0; tick();
  endtask

  task automatic miss_pulse();
    miss = 1'b1; tick();
    miss = 1'b0; tick();
  endtask

  task automatic show(input string tag);
    $display("step %s: state=%0d still=%0b score=%0h%0h balls=%0d",
             tag, game_state, gra_still, score_d1, score_d0, balls);
  endtask

  initial begin
    reset = 1'b0; btn = 2'b00; pix_x = 10'd5; pix_y = 10'd0; hit = 1'b0; miss = 1'b0;
    tick(); tick();
    check("rst_state", {6'd0, game_state}, 8'd0);
    check("rst_still", {7'd0, gra_still}, 8'd1);
    check("rst_score", {score_d1, score_d0}, 8'h00);
    check("rst_balls", {6'd0, balls}, 8'd3);
    reset = 1'b1; tick(); tick();
    check("idle_newgame", {6'd0, game_state}, 8'd0);
    show("reset");

    btn = 2'b01; tick(); btn = 2'b00;
    check("start_state", {6'd0, game_state}, 8'd1);
    check("start_still", {7'd0, gra_still}, 8'd0);
    show("start");

    hit = 1'b1; repeat (500) tick(); hit = 1'b0; tick();
    check("hit_level_once", {score_d1, score_d0}, 8'h01);
    repeat (36) hit_pulse();
    check("score_37", {score_d1, score_d0}, 8'h37);
    show("score37");

    reset = 1'b0; tick();
    check("midplay_rst_state", {6'd0, game_state}, 8'd0);
    check("midplay_rst_still", {7'd0, gra_still}, 8'd1);
    check("midplay_rst_score", {score_d1, score_d0}, 8'h00);
    check("midplay_rst_balls", {6'd0, balls}, 8'd3);
    reset = 1'b1; tick();
    show("midplay_reset");

    btn = 2'b10; tick(); btn = 2'b00;
    repeat (99) hit_pulse();
    check("score_99", {score_d1, score_d0}, 8'h99);
    check("balls_cap", {6'd0, balls}, 8'd3);

    miss_pulse();
    check("miss_newball", {6'd0, game_state}, 8'd2);
    check("miss_balls", {6'd0, balls}, 8'd2);
    check("newball_still", {7'd0, gra_still}, 8'd1);
    hit_pulse();
    check("hit_ignored_newball", {score_d1, score_d0}, 8'h99);
    show("newball");

    btn = 2'b01;
    frames(119);
    check("wait_119", {6'd0, game_state}, 8'd2);
    frames(1);
    check("relaunch_120", {6'd0, game_state}, 8'd1);
    btn = 2'b00;
    check("relaunch_still", {7'd0, gra_still}, 8'd0);

    hit_pulse();
    check("wrap_00", {score_d1, score_d0}, 8'h00);
`ifdef PONG_BONUS_BALL_EN
    exp_balls = 2'd3;
`else
    exp_balls = 2'd2;
`endif
    check("wrap_balls", {6'd0, balls}, {6'd0, exp_balls});
    show("wrap");

    hit = 1'b1; miss = 1'b1; tick(); hit = 1'b0; miss = 1'b0; tick();
    exp_balls = exp_balls - 2'd1;
    check("both_state", {6'd0, game_state}, 8'd2);
    check("both_score", {score_d1, score_d0}, 8'h00);
    check("both_balls", {6'd0, balls}, {6'd0, exp_balls});
    show("hit_and_miss");
    btn = 2'b01; frames(120); btn = 2'b00;
    check("back_play", {6'd0, game_state}, 8'd1);

`ifdef PONG_BONUS_BALL_EN
    miss_pulse();
    check("bonus_extra_miss", {6'd0, balls}, 8'd1);
    btn = 2'b01; frames(120); btn = 2'b00;
    check("bonus_back_play", {6'd0, game_state}, 8'd1);
`endif

    miss_pulse();
    check("over_state", {6'd0, game_state}, 8'd3);
    check("over_balls", {6'd0, balls}, 8'd0);
    check("over_still", {7'd0, gra_still}, 8'd1);
    show("over");
    btn = 2'b11;
    frames(119);
    check("over_btn_ignored", {6'd0, game_state}, 8'd3);
    btn = 2'b00;
    frames(1);
    check("over_to_newgame", {6'd0, game_state}, 8'd0);
    check("over_balls_reload", {6'd0, balls}, 8'd3);
    check("over_score_clear", {score_d1, score_d0}, 8'h00);
    check("newgame_still", {7'd0, gra_still}, 8'd1);
    show("newgame");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
